// File: rtl/msi_irq_sched_if.sv
// Interrupt scheduler bundle: request/moderation inputs from the rx/tx irq
// generators and the host config, plus the PCIe endpoint cfg_interrupt port.
// master: scheduler side (drives cfg_interrupt_n/di and msi_cnt).
// slave : environment side (irq generators, host config, endpoint).
interface msi_irq_sched_if #(
    parameter int TIMER_W = 16,
    parameter int CNT_W   = 16
);
    logic               rx_irq_req;          // level request, rx generator
    logic               tx_irq_req;          // level request, tx generator
    logic               rx_evt;              // 1-cycle pulse per rx pointer update
    logic               tx_evt;              // 1-cycle pulse per tx pointer update
    logic               irq_en;              // host MSI enable
    logic [TIMER_W-1:0] holdoff;             // min cycles between MSIs of one source
    logic [CNT_W-1:0]   pkt_th;              // event count that bypasses holdoff
    logic               cfg_interrupt_n;     // active-low interrupt request
    logic               cfg_interrupt_rdy_n; // active-low accept from endpoint
    logic [7:0]         cfg_interrupt_di;    // MSI vector
    logic [31:0]        msi_cnt;             // completed handshakes

    modport master (
        input  rx_irq_req, tx_irq_req, rx_evt, tx_evt, irq_en, holdoff, pkt_th,
        input  cfg_interrupt_rdy_n,
        output cfg_interrupt_n, cfg_interrupt_di, msi_cnt
    );

    modport slave (
        output rx_irq_req, tx_irq_req, rx_evt, tx_evt, irq_en, holdoff, pkt_th,
        output cfg_interrupt_rdy_n,
        input  cfg_interrupt_n, cfg_interrupt_di, msi_cnt
    );
endinterface

// File: rtl/msi_irq_sched.sv
// Purpose: moderates rx/tx interrupt requests (holdoff timer + event-count bypass),
//          round-robins them and drives the endpoint cfg_interrupt handshake.
// Latency: eligibility sampled in cycle N -> cfg_interrupt_n low in N+1; >=3 cycles between asserts.
// Backpressure: request held indefinitely until cfg_interrupt_rdy_n is sampled low; never aborted.
// Ports: clk, rst (sync, active-high); bus = msi_irq_sched_if.master (see interface for fields).
module msi_irq_sched #(
    parameter int TIMER_W = 16,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    msi_irq_sched_if.master   bus
);
    typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

    // Source index 0 = rx, 1 = tx; the index doubles as the MSI vector.
    state_t             state_q, state_d;
    logic               grant_q;
    logic               last_q;
    logic [TIMER_W-1:0] tmr_q [2];
    logic [CNT_W-1:0]   evc_q [2];
    logic [1:0]         req;
    logic [1:0]         evt;
    logic [1:0]         elig;
    logic [1:0]         done_src;
    logic               pick;
    logic               issue;
    logic               done;

    assign req = {bus.tx_irq_req, bus.rx_irq_req};
    assign evt = {bus.tx_evt, bus.rx_evt};

    // A source may fire once its holdoff has run out, or early once enough
    // events have piled up since its last MSI.
    always_comb begin
        elig = '0;
        for (int i = 0; i < 2; i++) begin
            elig[i] = req[i] & ((tmr_q[i] == '0) |
                                ((bus.pkt_th != '0) & (evc_q[i] >= bus.pkt_th)));
        end
    end

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        done    = 1'b0;
        // On a tie the source that did not complete last wins.
        pick    = (elig == 2'b11) ? ~last_q : elig[1];
        case (state_q)
            IDLE: begin
                if (bus.irq_en && (elig != 2'b00)) begin
                    issue   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (!bus.cfg_interrupt_rdy_n) begin
                    done    = 1'b1;
                    state_d = GAP;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign done_src = {done & grant_q, done & ~grant_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q              <= IDLE;
            grant_q              <= 1'b0;
            last_q               <= 1'b1;
            bus.cfg_interrupt_n  <= 1'b1;
            bus.cfg_interrupt_di <= 8'h00;
            bus.msi_cnt          <= 32'd0;
        end else begin
            state_q <= state_d;
            if (issue) begin
                grant_q              <= pick;
                bus.cfg_interrupt_di <= {7'd0, pick};
                bus.cfg_interrupt_n  <= 1'b0;
            end
            if (done) begin
                bus.cfg_interrupt_n <= 1'b1;
                last_q              <= grant_q;
                bus.msi_cnt         <= bus.msi_cnt + 32'd1;
            end
        end
    end

    // Moderation state keeps running for both sources regardless of FSM state.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                tmr_q[i] <= '0;
                evc_q[i] <= '0;
            end else if (done_src[i]) begin
                tmr_q[i] <= bus.holdoff;
                evc_q[i] <= CNT_W'(evt[i]);
            end else begin
                if (tmr_q[i] != '0) begin
                    tmr_q[i] <= tmr_q[i] - TIMER_W'(1);
                end
                if (evt[i] && (evc_q[i] != '1)) begin
                    evc_q[i] <= evc_q[i] + CNT_W'(1);
                end
            end
        end
    end
endmodule
